// File: rtl/ram_cfg_writer.sv
// Config-message sequencer: turns header + data-beat messages into consecutive
// RAM port-A writes, flagging messages whose s_last disagrees with the header count.
module ram_cfg_writer #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 32,
  parameter int CNT_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [ADDR_BITS-1:0] addra,
  output logic [DATA_BITS-1:0] dina,
  output logic                 ena,
  output logic                 wea,
  output logic                 busy,
  output logic                 done,
  output logic                 err_short,
  output logic                 err_long
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] curAddr_q, curAddr_d;
  logic [CNT_BITS-1:0]  rem_q, rem_d;
  logic [ADDR_BITS-1:0] addra_q, addra_d;
  logic [DATA_BITS-1:0] dina_q, dina_d;
  logic                 wea_q, wea_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 errShort_q, errShort_d;
  logic                 errLong_q, errLong_d;
  logic                 accept;
  logic                 lastOfN;

  assign s_ready = 1'b1;
  assign accept  = s_valid;
  // rem_q holds beats still expected minus one, so zero marks the Nth beat
  assign lastOfN = (rem_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      curAddr_q  <= '0;
      rem_q      <= '0;
      addra_q    <= '0;
      dina_q     <= '0;
      wea_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      errShort_q <= 1'b0;
      errLong_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      curAddr_q  <= curAddr_d;
      rem_q      <= rem_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      wea_q      <= wea_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      errShort_q <= errShort_d;
      errLong_q  <= errLong_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    curAddr_d = curAddr_q;
    rem_d     = rem_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !s_last) begin
          state_d   = WRITE;
          curAddr_d = s_data[ADDR_BITS-1:0];
          rem_d     = s_data[ADDR_BITS+CNT_BITS-1:ADDR_BITS];
        end
      end
      WRITE: begin
        if (accept) begin
          curAddr_d = curAddr_q + 1'b1;
          rem_d     = rem_q - 1'b1;
          if (s_last)       state_d = IDLE;
          else if (lastOfN) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (accept && s_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addra_d    = addra_q;
    dina_d     = dina_q;
    wea_d      = 1'b0;
    done_d     = 1'b0;
    errShort_d = 1'b0;
    errLong_d  = 1'b0;
    busy_d     = (state_d != IDLE);
    if (state_q == WRITE && accept) begin
      wea_d      = 1'b1;
      addra_d    = curAddr_q;
      dina_d     = s_data;
      done_d     = s_last && lastOfN;
      errShort_d = s_last && !lastOfN;
      errLong_d  = !s_last && lastOfN;
    end else if (state_q == IDLE && accept && s_last) begin
      errShort_d = 1'b1;
    end
  end

  assign addra     = addra_q;
  assign dina      = dina_q;
  assign ena       = wea_q;
  assign wea       = wea_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_short = errShort_q;
  assign err_long  = errLong_q;

endmodule
